// File: rtl/sync_down_cntr_pkg.sv
// Shared constants for the synchronous loadable down counter.
package sync_down_cntr_pkg;

   // Default counter width for instances that do not override WIDTH.
   localparam int CNTR_W = 4;

endpackage

// File: rtl/sync_down_cntr.sv
// Synchronous loadable down counter with modulo wrap or auto-reload, cascadable via borrow.
module sync_down_cntr
   import sync_down_cntr_pkg::*;
#(
   parameter int WIDTH = CNTR_W
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic             zero,
   output logic             borrow,
   output logic             done
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic             at_zero;

   assign at_zero = (q_q == '0);

   // load beats en; a wrap picks all-ones or the reload register.
   always_comb begin
      q_d      = q_q;
      reload_d = reload_q;
      done_d   = done_q;
      if (load) begin
         q_d      = load_val;
         reload_d = load_val;
         done_d   = 1'b0;
      end else if (en) begin
         if (at_zero) begin
            q_d = auto_reload ? reload_q : ALL_ONES;
         end else begin
            q_d = q_q - ONE;
            if (q_q == ONE) begin
               done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         q_q      <= '0;
         reload_q <= ALL_ONES;
         done_q   <= 1'b0;
      end else begin
         q_q      <= q_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign q      = q_q;
   assign zero   = at_zero;
   // Qualified so a higher stage only steps on an edge that really wraps this one.
   assign borrow = en & at_zero & ~load & ~clear;
   assign done   = done_q;

endmodule

// File: tb/tb_sync_down_cntr.sv
// Directed and randomized checks of sync_down_cntr against an arithmetic reference model.
module tb_sync_down_cntr;

   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         clear, load, en, auto_reload;
   logic [W-1:0] load_val;
   logic [W-1:0] q;
   logic         zero, borrow, done;

   // Two-stage cascade
   logic         c_clear, c_load, c_en;
   logic [W-1:0] lo_q, hi_q;
   logic         lo_zero, lo_borrow, lo_done;
   logic         hi_zero, hi_borrow, hi_done;

   int checks   = 0;
   int failures = 0;
   bit started  = 0;

   // Reference model state
   int m_q, m_rel;
   bit m_done;
   int c_val;
   bit c_ldone, c_hdone;

   always #5 clk = ~clk;

   sync_down_cntr #(.WIDTH(W)) dut (
      .clk(clk), .clear(clear), .load(load), .load_val(load_val), .en(en),
      .auto_reload(auto_reload), .q(q), .zero(zero), .borrow(borrow), .done(done)
   );

   sync_down_cntr #(.WIDTH(W)) u_lo (
      .clk(clk), .clear(c_clear), .load(c_load), .load_val(4'h0), .en(c_en),
      .auto_reload(1'b0), .q(lo_q), .zero(lo_zero), .borrow(lo_borrow), .done(lo_done)
   );

   sync_down_cntr #(.WIDTH(W)) u_hi (
      .clk(clk), .clear(c_clear), .load(c_load), .load_val(4'h0), .en(lo_borrow),
      .auto_reload(1'b0), .q(hi_q), .zero(hi_zero), .borrow(hi_borrow), .done(hi_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of the single counter: drive, check pre-edge outputs, advance model.
   task automatic step(input bit c, input bit l, input int lv, input bit e, input bit ar);
      bit exp_borrow;
      clear = c; load = l; load_val = lv[W-1:0]; en = e; auto_reload = ar;
      #1;
      exp_borrow = e && (m_q == 0) && !l && !c;
      if (started) begin
         check("q", q, m_q);
         check("zero", zero, m_q == 0);
         check("borrow", borrow, exp_borrow);
         check("done", done, m_done);
      end
      $display("step clr=%0b ld=%0b lv=%0h en=%0b ar=%0b q=%0h z=%0b b=%0b d=%0b",
               c, l, lv[W-1:0], e, ar, q, zero, borrow, done);
      @(posedge clk);
      if (c) begin
         m_q = 0; m_rel = MASK; m_done = 0;
      end else if (l) begin
         m_q = lv & MASK; m_rel = lv & MASK; m_done = 0;
      end else if (e) begin
         if (m_q == 0) m_q = ar ? m_rel : MASK;
         else begin
            if (m_q == 1) m_done = 1;
            m_q = m_q - 1;
         end
      end
      @(negedge clk);
   endtask

   // One clock of the cascade: the pair must behave as one 8-bit down counter.
   task automatic cstep(input bit l, input bit e);
      int lo, hi;
      c_load = l; c_en = e;
      #1;
      lo = c_val & MASK;
      hi = (c_val >> W) & MASK;
      check("casc_val", {hi_q, lo_q}, c_val);
      check("casc_lo_borrow", lo_borrow, e && lo == 0 && !l);
      check("casc_hi_borrow", hi_borrow, e && c_val == 0 && !l);
      check("casc_zero", {hi_zero, lo_zero}, {hi == 0, lo == 0});
      check("casc_done", {hi_done, lo_done}, {c_hdone, c_ldone});
      $display("cstep ld=%0b en=%0b val=%02h", l, e, {hi_q, lo_q});
      @(posedge clk);
      if (l) begin
         c_val = 0; c_ldone = 0; c_hdone = 0;
      end else if (e) begin
         if (lo == 1) c_ldone = 1;
         if (lo == 0 && hi == 1) c_hdone = 1;
         c_val = (c_val + 255) % 256;
      end
      @(negedge clk);
   endtask

   initial begin
      clear = 0; load = 0; load_val = '0; en = 0; auto_reload = 0;
      c_clear = 1; c_load = 0; c_en = 0;
      m_q = 0; m_rel = MASK; m_done = 0;
      c_val = 0; c_ldone = 0; c_hdone = 0;
      @(negedge clk);

      // Reset, then free-run modulo 16
      step(1, 0, 0, 0, 0);
      started = 1;
      for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);

      // Auto-reload interval of 6
      step(0, 1, 5, 0, 1);
      for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 1);

      // Load overrides decrement at q=3, and at q=0 (no borrow)
      step(0, 1, 3, 0, 0);
      step(0, 1, 9, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 9, 1, 0);
      step(0, 0, 0, 0, 0);

      // Clear beats load mid-count; reload register returns to all-ones
      step(0, 1, 7, 0, 0);
      step(1, 1, 2, 1, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);

      // Reload 0 in auto-reload mode: divide-by-1
      step(0, 1, 0, 0, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);

      // Clear asserted while q is zero and enabled
      step(0, 0, 0, 1, 1);
      step(1, 0, 0, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
              int'($urandom_range(0, MASK)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1);
      end

      // Cascade: clear, load both with 0, then count (mostly enabled)
      @(posedge clk);
      @(negedge clk);
      c_clear = 0;
      cstep(1, 1);
      for (int i = 0; i < 300; i++) cstep(0, $urandom_range(0, 7) != 0);
      cstep(1, 0);
      for (int i = 0; i < 20; i++) cstep(0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
